// File: rtl/greater_than_checker.sv
// Response-side checker for a WIDTH-bit greater-than comparator.
// Walks every {A,B} operand pair, holds each pair for HOLD_CYCLES clocks,
// samples the comparator's answer and keeps a saturating mismatch count
// together with the first failing vector.
module greater_than_checker #(
    parameter int WIDTH       = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic                 f_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [2*WIDTH-1:0]   first_fail_vec,
    output logic                 first_fail_valid
);

    localparam int VEC_W = 2 * WIDTH;
    // Hold counter needs at least one bit even when HOLD_CYCLES is 1.
    localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r,            state_s;
    logic [VEC_W-1:0]   vec_r,              vec_s;
    logic [HC_W-1:0]    hold_cnt_r,         hold_cnt_s;
    logic [ERR_W-1:0]   err_count_r,        err_count_s;
    logic [VEC_W-1:0]   first_fail_vec_r,   first_fail_vec_s;
    logic               first_fail_valid_r, first_fail_valid_s;
    logic               busy_r,             busy_s;
    logic               done_r,             done_s;
    logic               pass_r,             pass_s;

    logic               sample_hit_s;
    logic               expected_s;
    logic               mismatch_s;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
        logic [ERR_W-1:0] result;
        if (value == {ERR_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + ERR_W'(1);
        end
        return result;
    endfunction

    // The operands are driven straight from the vector register, so they are registered.
    assign a_out = vec_r[VEC_W-1:WIDTH];
    assign b_out = vec_r[WIDTH-1:0];

    assign sample_hit_s = (hold_cnt_r == HC_W'(HOLD_CYCLES - 1));
    assign expected_s   = (a_out > b_out);
    assign mismatch_s   = (f_in != expected_s);

    // Next-state and next-result logic for the sweep controller.
    always_comb begin
        state_s            = state_r;
        vec_s              = vec_r;
        hold_cnt_s         = hold_cnt_r;
        err_count_s        = err_count_r;
        first_fail_vec_s   = first_fail_vec_r;
        first_fail_valid_s = first_fail_valid_r;
        busy_s             = busy_r;
        done_s             = done_r;
        pass_s             = pass_r;

        case (state_r)
            ST_IDLE: begin
                err_count_s        = {ERR_W{1'b0}};
                first_fail_vec_s   = {VEC_W{1'b0}};
                first_fail_valid_s = 1'b0;
                done_s             = 1'b0;
                pass_s             = 1'b0;
                if (start) begin
                    state_s    = ST_DRIVE;
                    vec_s      = {VEC_W{1'b0}};
                    hold_cnt_s = {HC_W{1'b0}};
                    busy_s     = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end
            end

            ST_DRIVE: begin
                busy_s = 1'b1;
                if (sample_hit_s) begin
                    if (mismatch_s) begin
                        err_count_s = sat_inc(err_count_r);
                        if (!first_fail_valid_r) begin
                            first_fail_vec_s   = vec_r;
                            first_fail_valid_s = 1'b1;
                        end else begin
                            first_fail_vec_s   = first_fail_vec_r;
                            first_fail_valid_s = first_fail_valid_r;
                        end
                    end else begin
                        err_count_s = err_count_r;
                    end

                    hold_cnt_s = {HC_W{1'b0}};
                    // Last vector sampled: stop on it rather than wrapping to zero.
                    if (vec_r == {VEC_W{1'b1}}) begin
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        pass_s  = (err_count_s == {ERR_W{1'b0}});
                    end else begin
                        vec_s = vec_r + VEC_W'(1);
                    end
                end else begin
                    hold_cnt_s = hold_cnt_r + HC_W'(1);
                end
            end

            ST_DONE: begin
                // A new start behaves exactly like a start from idle.
                if (start) begin
                    state_s            = ST_DRIVE;
                    vec_s              = {VEC_W{1'b0}};
                    hold_cnt_s         = {HC_W{1'b0}};
                    err_count_s        = {ERR_W{1'b0}};
                    first_fail_vec_s   = {VEC_W{1'b0}};
                    first_fail_valid_s = 1'b0;
                    busy_s             = 1'b1;
                    done_s             = 1'b0;
                    pass_s             = 1'b0;
                end else begin
                    state_s = ST_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end
            end

            default: begin
                state_s            = ST_IDLE;
                vec_s              = {VEC_W{1'b0}};
                hold_cnt_s         = {HC_W{1'b0}};
                err_count_s        = {ERR_W{1'b0}};
                first_fail_vec_s   = {VEC_W{1'b0}};
                first_fail_valid_s = 1'b0;
                busy_s             = 1'b0;
                done_s             = 1'b0;
                pass_s             = 1'b0;
            end
        endcase
    end

    // State and result registers; reset aborts any sweep and clears every output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r            <= ST_IDLE;
            vec_r              <= {VEC_W{1'b0}};
            hold_cnt_r         <= {HC_W{1'b0}};
            err_count_r        <= {ERR_W{1'b0}};
            first_fail_vec_r   <= {VEC_W{1'b0}};
            first_fail_valid_r <= 1'b0;
            busy_r             <= 1'b0;
            done_r             <= 1'b0;
            pass_r             <= 1'b0;
        end else begin
            state_r            <= state_s;
            vec_r              <= vec_s;
            hold_cnt_r         <= hold_cnt_s;
            err_count_r        <= err_count_s;
            first_fail_vec_r   <= first_fail_vec_s;
            first_fail_valid_r <= first_fail_valid_s;
            busy_r             <= busy_s;
            done_r             <= done_s;
            pass_r             <= pass_s;
        end
    end

    assign busy             = busy_r;
    assign done             = done_r;
    assign pass             = pass_r;
    assign err_count        = err_count_r;
    assign first_fail_vec   = first_fail_vec_r;
    assign first_fail_valid = first_fail_valid_r;

endmodule

// File: tb/tb_greater_than_checker.sv
// Bench for greater_than_checker: three instances (default, 3-bit error
// counter, single-cycle hold) each driven by a behavioural comparator whose
// behaviour (correct, stuck-at-0, inverted) is chosen per sweep.
module tb_greater_than_checker;

    typedef struct {
        int         lat;
        logic [7:0] err;
        logic [3:0] ffv;
        logic       ffvalid;
        logic       pass;
    } exp_t;

    exp_t exp_q[$];

    logic clk;
    logic rst_n;
    logic start0, start1, start2;
    int   mode0, mode1, mode2;

    logic [1:0] a0, b0, a1, b1, a2, b2;
    logic       f0, f1, f2;
    logic       busy0, done0, pass0, ffval0;
    logic       busy1, done1, pass1, ffval1;
    logic       busy2, done2, pass2, ffval2;
    logic [7:0] err0, err2;
    logic [2:0] err1;
    logic [3:0] ffv0, ffv1, ffv2;

    int n_checks;
    int n_errors;

    // Comparator under test: 0 correct, 1 stuck at 0, 2 inverted.
    function automatic logic cmp_model(input int m, input logic [1:0] a, input logic [1:0] b);
        logic r;
        case (m)
            1:       r = 1'b0;
            2:       r = ~(a > b);
            default: r = (a > b);
        endcase
        return r;
    endfunction

    assign f0 = cmp_model(mode0, a0, b0);
    assign f1 = cmp_model(mode1, a1, b1);
    assign f2 = cmp_model(mode2, a2, b2);

    greater_than_checker #(.WIDTH(2), .HOLD_CYCLES(4), .ERR_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a_out(a0), .b_out(b0), .f_in(f0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_valid(ffval0));

    greater_than_checker #(.WIDTH(2), .HOLD_CYCLES(4), .ERR_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1), .f_in(f1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_valid(ffval1));

    greater_than_checker #(.WIDTH(2), .HOLD_CYCLES(1), .ERR_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2), .f_in(f2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_vec(ffv2), .first_fail_valid(ffval2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        case (which)
            1:       start1 = v;
            2:       start2 = v;
            default: start0 = v;
        endcase
    endtask

    task automatic get_obs(input int which, output logic done, output logic busy,
                           output logic pass, output logic ffval, output logic [7:0] err,
                           output logic [3:0] ffv, output logic [3:0] ab);
        case (which)
            1: begin
                done = done1; busy = busy1; pass = pass1; ffval = ffval1;
                err = {5'd0, err1}; ffv = ffv1; ab = {a1, b1};
            end
            2: begin
                done = done2; busy = busy2; pass = pass2; ffval = ffval2;
                err = err2; ffv = ffv2; ab = {a2, b2};
            end
            default: begin
                done = done0; busy = busy0; pass = pass0; ffval = ffval0;
                err = err0; ffv = ffv0; ab = {a0, b0};
            end
        endcase
    endtask

    // Expected sweep result computed from the definition A>B over all 16 vectors.
    task automatic push_expect(input int mode, input int hold, input int errw);
        exp_t       e;
        int         cnt;
        int         maxv;
        logic [3:0] v;
        logic       f;
        cnt       = 0;
        maxv      = (1 << errw) - 1;
        e.ffv     = 4'd0;
        e.ffvalid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            f = cmp_model(mode, v[3:2], v[1:0]);
            if (f != (v[3:2] > v[1:0])) begin
                if (cnt < maxv) cnt++;
                if (!e.ffvalid) begin
                    e.ffv     = v;
                    e.ffvalid = 1'b1;
                end
            end
        end
        e.lat  = 16 * hold;
        e.err  = 8'(cnt);
        e.pass = (cnt == 0);
        exp_q.push_back(e);
    endtask

    // Starts a sweep, waits (bounded) for done, then pops and compares the result.
    task automatic run_sweep(input int which, input string tag, input int pulse_at);
        exp_t       e;
        int         n;
        logic       d, bsy, p, fv;
        logic [7:0] er;
        logic [3:0] ffv, ab;
        logic       busy_bad;
        @(negedge clk);
        set_start(which, 1'b1);
        @(posedge clk);
        #1;
        set_start(which, 1'b0);
        get_obs(which, d, bsy, p, fv, er, ffv, ab);
        check_val({tag, "_clr_err"}, 32'(er), 32'd0);
        check_val({tag, "_clr_done"}, 32'(d), 32'd0);
        n        = 0;
        busy_bad = 1'b0;
        d        = 1'b0;
        while (!d && n < 300) begin
            if (!bsy) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            set_start(which, 1'b0);
            n++;
            get_obs(which, d, bsy, p, fv, er, ffv, ab);
            if (n == pulse_at) set_start(which, 1'b1);
        end
        e = exp_q.pop_front();
        check_val({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
        check_val({tag, "_latency"}, 32'(n), 32'(e.lat));
        check_val({tag, "_busy_end"}, 32'(bsy), 32'd0);
        check_val({tag, "_err"}, 32'(er), 32'(e.err));
        check_val({tag, "_ffv"}, 32'(ffv), 32'(e.ffv));
        check_val({tag, "_ffvalid"}, 32'(fv), 32'(e.ffvalid));
        check_val({tag, "_pass"}, 32'(p), 32'(e.pass));
        check_val({tag, "_final_vec"}, 32'(ab), 32'hF);
        // Results must stay stable while start stays low.
        repeat (3) @(posedge clk);
        #1;
        get_obs(which, d, bsy, p, fv, er, ffv, ab);
        check_val({tag, "_hold_done"}, 32'(d), 32'd1);
        check_val({tag, "_hold_err"}, 32'(er), 32'(e.err));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n  = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        mode0  = 0;    mode1  = 2;    mode2  = 0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_outs", {16'd0, a0, b0, busy0, done0, pass0, err0, ffv0, ffval0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Correct comparator.
        mode0 = 0;
        push_expect(0, 4, 8);
        run_sweep(0, "correct", -1);

        // Stuck-at-0 comparator.
        mode0 = 1;
        push_expect(1, 4, 8);
        run_sweep(0, "stuck0", -1);

        // Restart after a failing sweep clears results and passes.
        mode0 = 0;
        push_expect(0, 4, 8);
        run_sweep(0, "restart", -1);

        // Inverted comparator.
        mode0 = 2;
        push_expect(2, 4, 8);
        run_sweep(0, "invert", -1);

        // Start pulsed mid-sweep (vector 3 driven) must be ignored.
        mode0 = 0;
        push_expect(0, 4, 8);
        run_sweep(0, "midstart", 13);

        // Reset while vector 7 is driven: everything returns to zero.
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        mode0  = 1;
        repeat (30) @(posedge clk);
        #1;
        check_val("pre_rst_vec", 32'({a0, b0}), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_outs", {16'd0, a0, b0, busy0, done0, pass0, err0, ffv0, ffval0}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mode0 = 0;
        push_expect(0, 4, 8);
        run_sweep(0, "post_rst", -1);

        // Saturating 3-bit error counter with an inverted comparator.
        push_expect(2, 4, 3);
        run_sweep(1, "sat", -1);

        // Single-cycle hold.
        push_expect(0, 1, 8);
        run_sweep(2, "hold1", -1);

        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
